// File: rtl/ir_tx_pkg.sv
// ---------------------------------------------------------------------------
// ir_tx_pkg
// Shared definitions for the IR transmit sequencer:
//   - direction codes understood by the packet generator
//   - sequencer state encoding
//   - is_valid_dir(): rejects physically contradictory direction codes
// ---------------------------------------------------------------------------
package ir_tx_pkg;

    localparam int DIR_W = 4;

    localparam logic [DIR_W-1:0] IDLE          = 4'b0000;
    localparam logic [DIR_W-1:0] Forwards      = 4'b1000;
    localparam logic [DIR_W-1:0] Backwards     = 4'b0100;
    localparam logic [DIR_W-1:0] Left          = 4'b0010;
    localparam logic [DIR_W-1:0] Right         = 4'b0001;
    localparam logic [DIR_W-1:0] ForwardLeft   = 4'b1010;
    localparam logic [DIR_W-1:0] ForwardRight  = 4'b1001;
    localparam logic [DIR_W-1:0] BackwardLeft  = 4'b0110;
    localparam logic [DIR_W-1:0] BackwardRight = 4'b0101;

    // LOAD_WAIT: nothing new was loaded at the last boundary (held or idle).
    // SEND:      a queued command is being transmitted.
    typedef enum logic {
        LOAD_WAIT = 1'b0,
        SEND      = 1'b1
    } seq_state_t;

    // Only the nine enumerated codes may reach the packet generator;
    // F+B or L+R combinations are contradictory and are refused.
    function automatic logic is_valid_dir(input logic [DIR_W-1:0] dir);
        logic ok;
        case (dir)
            IDLE, Forwards, Backwards, Left, Right,
            ForwardLeft, ForwardRight, BackwardLeft, BackwardRight: ok = 1'b1;
            default:                                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ir_cmd_fifo
// Synchronous FIFO holding {car, command} entries for the sequencer.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   flush      synchronous clear of all entries (wins over push/pop)
//   push/wdata write one entry (ignored when full)
//   pop/rdata  rdata is the head entry; pop removes it (ignored when empty)
//   full/empty/level  occupancy status derived from the registered count
// ---------------------------------------------------------------------------
module ir_cmd_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/ir_tx_sequencer.sv
// ---------------------------------------------------------------------------
// ir_tx_sequencer
// Queues direction commands per target car and presents one command/car
// pair to the packet generator for a whole packet sequence, changing only
// at sequence boundaries.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   CMD_IN, CAR_IN      offered command and target car
//   cmd_valid/cmd_ready command handshake (ready = queue not full)
//   abort               synchronous flush of queue and current sequence
//   pack_strobe         one-cycle strobe at each packet start
//   pack_gen_EN         packet generation enable (freezes sequencing when 0)
//   current_dir_state   command presented to the packet generator
//   current_car         car presented to the packet generator
//   pkt_count           packets sent in the current sequence
//   seq_done            one-cycle pulse after each sequence boundary
//   queue_level         number of queued commands
//   cmd_dropped         one-cycle pulse after an invalid command was offered
// ---------------------------------------------------------------------------
module ir_tx_sequencer
    import ir_tx_pkg::*;
#(
    parameter int CMD_WIDTH       = 4,
    parameter int NUM_CARS        = 4,
    parameter int CAR_W           = 2,
    parameter int PACKETS_PER_SEQ = 10,
    parameter int CNT_W           = 4,
    parameter int QUEUE_DEPTH     = 4,
    parameter int HOLD_LAST       = 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [CMD_WIDTH-1:0]           CMD_IN,
    input  logic [CAR_W-1:0]               CAR_IN,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           abort,
    input  logic                           pack_strobe,
    input  logic                           pack_gen_EN,
    output logic [CMD_WIDTH-1:0]           current_dir_state,
    output logic [CAR_W-1:0]               current_car,
    output logic [CNT_W-1:0]               pkt_count,
    output logic                           seq_done,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
    output logic                           cmd_dropped
);

    localparam int ENTRY_W = CMD_WIDTH + CAR_W;

    seq_state_t            state;
    seq_state_t            state_n;
    logic [CMD_WIDTH-1:0]  dir_n;
    logic [CAR_W-1:0]      car_n;
    logic [CNT_W-1:0]      cnt_n;
    logic                  done_n;

    logic                  cmd_ok;
    logic                  push;
    logic                  pop;
    logic                  strobe_en;
    logic                  boundary;
    logic                  q_full;
    logic                  q_empty;
    logic [ENTRY_W-1:0]    q_head;
    logic [CMD_WIDTH-1:0]  head_dir;
    logic [CAR_W-1:0]      head_car;

    // Car range check is done one bit wider so NUM_CARS == 2**CAR_W works.
    assign cmd_ok = is_valid_dir(CMD_IN) &&
                    ({1'b0, CAR_IN} < (CAR_W+1)'(NUM_CARS));

    // Depends only on registered occupancy (and reset), never on strobes.
    assign cmd_ready = !q_full && !RST;

    assign push      = cmd_valid && cmd_ready && cmd_ok && !abort;
    assign strobe_en = pack_gen_EN && pack_strobe && !abort;
    assign boundary  = strobe_en && (pkt_count == CNT_W'(PACKETS_PER_SEQ - 1));
    // Pop decision uses the pre-edge empty flag, so a command pushed on a
    // boundary cycle into an empty queue waits for the next boundary.
    assign pop       = boundary && !q_empty;

    assign {head_car, head_dir} = q_head;

    ir_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .flush (abort),
        .push  (push),
        .wdata ({CAR_IN, CMD_IN}),
        .pop   (pop),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .level (queue_level)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state             <= LOAD_WAIT;
            current_dir_state <= IDLE;
            current_car       <= '0;
            pkt_count         <= '0;
            seq_done          <= 1'b0;
            cmd_dropped       <= 1'b0;
        end else begin
            state             <= state_n;
            current_dir_state <= dir_n;
            current_car       <= car_n;
            pkt_count         <= cnt_n;
            seq_done          <= done_n;
            cmd_dropped       <= cmd_valid && !cmd_ok;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = current_dir_state;
        car_n   = current_car;
        cnt_n   = pkt_count;
        done_n  = 1'b0;

        if (abort) begin
            state_n = LOAD_WAIT;
            dir_n   = IDLE;
            cnt_n   = '0;
        end else if (strobe_en) begin
            if (boundary) begin
                cnt_n  = '0;
                done_n = 1'b1;
                if (!q_empty) begin
                    state_n = SEND;
                    dir_n   = head_dir;
                    car_n   = head_car;
                end else begin
                    state_n = LOAD_WAIT;
                    // In LOAD_WAIT the output is already idle or held.
                    if (HOLD_LAST == 0 && state == SEND) dir_n = IDLE;
                end
            end else begin
                cnt_n = pkt_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ir_tx_sequencer.sv
module tb_ir_tx_sequencer;

    localparam int NC    = 3;   // car 3 is addressable on the bus but invalid
    localparam int PPS   = 10;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] CMD_IN = '0;
    logic [1:0] CAR_IN = '0;
    logic       cmd_valid = 1'b0;
    logic       abort = 1'b0;
    logic       pack_strobe = 1'b0;
    logic       pack_gen_EN = 1'b0;

    logic       h_ready, i_ready;
    logic [3:0] h_dir, i_dir;
    logic [1:0] h_car, i_car;
    logic [3:0] h_cnt, i_cnt;
    logic       h_done, i_done;
    logic [2:0] h_lvl, i_lvl;
    logic       h_drop, i_drop;

    ir_tx_sequencer #(.NUM_CARS(NC), .HOLD_LAST(1)) dut_h (
        .CLK(CLK), .RST(RST), .CMD_IN(CMD_IN), .CAR_IN(CAR_IN),
        .cmd_valid(cmd_valid), .cmd_ready(h_ready), .abort(abort),
        .pack_strobe(pack_strobe), .pack_gen_EN(pack_gen_EN),
        .current_dir_state(h_dir), .current_car(h_car), .pkt_count(h_cnt),
        .seq_done(h_done), .queue_level(h_lvl), .cmd_dropped(h_drop));

    ir_tx_sequencer #(.NUM_CARS(NC), .HOLD_LAST(0)) dut_i (
        .CLK(CLK), .RST(RST), .CMD_IN(CMD_IN), .CAR_IN(CAR_IN),
        .cmd_valid(cmd_valid), .cmd_ready(i_ready), .abort(abort),
        .pack_strobe(pack_strobe), .pack_gen_EN(pack_gen_EN),
        .current_dir_state(i_dir), .current_car(i_car), .pkt_count(i_cnt),
        .seq_done(i_done), .queue_level(i_lvl), .cmd_dropped(i_drop));

    always #5 CLK = ~CLK;

    int nchk  = 0;
    int npass = 0;

    // Scoreboard of accepted {car, cmd} entries, plus the reference state.
    logic [5:0] sb [$];
    int         m_cnt;
    logic [3:0] m_dir_h;
    logic [3:0] m_dir_i;
    logic [1:0] m_car;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic ref_valid(input logic [3:0] c, input logic [1:0] car);
        return !(c[3] && c[2]) && !(c[1] && c[0]) && (int'(car) < NC);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ready_h"}, h_ready, 0);  chk({tag, "_ready_i"}, i_ready, 0);
        chk({tag, "_dir_h"},   h_dir, 0);    chk({tag, "_dir_i"},   i_dir, 0);
        chk({tag, "_car_h"},   h_car, 0);    chk({tag, "_car_i"},   i_car, 0);
        chk({tag, "_cnt_h"},   h_cnt, 0);    chk({tag, "_cnt_i"},   i_cnt, 0);
        chk({tag, "_done_h"},  h_done, 0);   chk({tag, "_done_i"},  i_done, 0);
        chk({tag, "_lvl_h"},   h_lvl, 0);    chk({tag, "_lvl_i"},   i_lvl, 0);
        chk({tag, "_drop_h"},  h_drop, 0);   chk({tag, "_drop_i"},  i_drop, 0);
    endtask

    // One clock cycle: drive inputs, advance the reference, then compare.
    task automatic cyc(input logic v, input logic [3:0] c, input logic [1:0] car,
                       input logic s, input logic en, input logic ab);
        logic       ready, ok, e_done, e_drop;
        logic [5:0] e;
        CMD_IN = c; CAR_IN = car; cmd_valid = v;
        pack_strobe = s; pack_gen_EN = en; abort = ab;
        ready = (sb.size() < DEPTH);
        chk("ready_h", h_ready, ready);
        chk("ready_i", i_ready, ready);
        ok     = ref_valid(c, car);
        e_drop = v && !ok;
        e_done = 1'b0;
        if (ab) begin
            sb.delete();
            m_cnt = 0; m_dir_h = 4'b0000; m_dir_i = 4'b0000;
        end else begin
            if (en && s) begin
                if (m_cnt == PPS - 1) begin
                    m_cnt  = 0;
                    e_done = 1'b1;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        m_dir_h = e[3:0]; m_dir_i = e[3:0]; m_car = e[5:4];
                    end else begin
                        m_dir_i = 4'b0000;
                    end
                end else begin
                    m_cnt++;
                end
            end
            if (v && ok && ready) sb.push_back({car, c});
        end
        @(posedge CLK); #1;
        cmd_valid = 1'b0; pack_strobe = 1'b0; abort = 1'b0;
        chk("cnt_h", h_cnt, m_cnt);        chk("cnt_i", i_cnt, m_cnt);
        chk("done_h", h_done, e_done);     chk("done_i", i_done, e_done);
        chk("dir_h", h_dir, m_dir_h);      chk("dir_i", i_dir, m_dir_i);
        chk("car_h", h_car, m_car);        chk("car_i", i_car, m_car);
        chk("lvl_h", h_lvl, sb.size());    chk("lvl_i", i_lvl, sb.size());
        chk("drop_h", h_drop, e_drop);     chk("drop_i", i_drop, e_drop);
    endtask

    task automatic strobes(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
            cyc(1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        m_cnt = 0; m_dir_h = 4'b0000; m_dir_i = 4'b0000; m_car = 2'd0;

        // Reset state
        #2 RST = 1'b1;
        #2 chk_reset("rst");
        repeat (2) @(posedge CLK);
        #1 chk_reset("rst_hold");
        RST = 1'b0;
        #1 chk("ready_after_rst", h_ready, 1);

        // Single command to car 2 through a full sequence
        cyc(1'b1, 4'b1000, 2'd2, 1'b0, 1'b1, 1'b0);
        strobes(PPS);
        cyc(1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);

        // Invalid code and invalid car are dropped
        cyc(1'b1, 4'b1100, 2'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b0010, 2'd3, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b0011, 2'd1, 1'b0, 1'b1, 1'b0);

        // Fill past capacity; fifth push is refused, drop works while full
        cyc(1'b1, 4'b1000, 2'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b0100, 2'd1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b0010, 2'd2, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b1010, 2'd1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b1111, 2'd0, 1'b0, 1'b1, 1'b0);

        // Boundary with full queue plus push: pop only
        strobes(PPS - 1);
        cyc(1'b1, 4'b0101, 2'd1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        // Boundary with non-empty queue plus push: both, level unchanged
        strobes(PPS - 1);
        cyc(1'b1, 4'b0110, 2'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        // Drain remaining entries in order
        strobes(3 * PPS);

        // Left sequence, then empty-queue boundary with a push (no bypass)
        cyc(1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
        strobes(PPS);
        strobes(PPS - 1);
        cyc(1'b1, 4'b0001, 2'd2, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        strobes(PPS);

        // Abort mid-sequence with three queued, colliding with push and strobe
        cyc(1'b1, 4'b1000, 2'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b0100, 2'd1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b1001, 2'd2, 1'b0, 1'b1, 1'b0);
        strobes(6);
        cyc(1'b1, 4'b1000, 2'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);

        // Enable low: strobes ignored, pushes still accepted
        cyc(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'b1000, 2'd1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
        strobes(PPS);
        strobes(4);

        // Asynchronous reset between clock edges at pkt_count 4
        cyc(1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        #3 RST = 1'b1;
        #1 chk_reset("async_rst");
        sb.delete();
        m_cnt = 0; m_dir_h = 4'b0000; m_dir_i = 4'b0000; m_car = 2'd0;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Normal operation after reset
        cyc(1'b1, 4'b1001, 2'd1, 1'b0, 1'b1, 1'b0);
        strobes(PPS);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
